// File: rtl/ktc32_top.sv
// ktc32_top: multi-cycle KTC32 core (IF/EX/MEM) with a 4 KiB unified RAM and a 4-bit LED register.
// Optional build macro `KTC32_HALT_EN: opcode 0x3F parks the core in HALTED until reset.
module ktc32_ram (
  input  logic        clk,
  input  logic [9:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:1023];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

module ktc32_top (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] led
);
  localparam int DATA_W = 32;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h09, OP_LUI = 6'h0A,
                         OP_LW = 6'h10, OP_SW = 6'h11, OP_BEQ = 6'h18,
                         OP_BNE = 6'h19, OP_JAL = 6'h1A, OP_JALR = 6'h1B,
                         OP_HALT = 6'h3F;

`ifdef KTC32_HALT_EN
  typedef enum logic [1:0] {S_IF, S_EX, S_MEM, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IF, S_EX, S_MEM} state_t;
`endif

  state_t                   state, state_nxt;
  logic [DATA_W-1:0]        pc, pc_nxt, wb_val, ram_rdata, ram_wdata;
  logic [DATA_W-1:0]        rf [0:15];
  logic [9:0]               ram_addr;
  logic                     ram_we, wb_en, ld_led;
  logic [3:0]               ld_rd;

  // The RAM output register holds the fetched instruction for the whole EX cycle.
  logic [5:0]               op;
  logic [3:0]               rd, rs1, rs2;
  logic [15:0]              imm;
  logic signed [DATA_W-1:0] simm, a, b, d, ea;
  logic [DATA_W-1:0]        pc_br, pc_inc;

  assign op     = ram_rdata[31:26];
  assign rd     = ram_rdata[25:22];
  assign rs1    = ram_rdata[21:18];
  assign rs2    = ram_rdata[17:14];
  assign imm    = ram_rdata[15:0];
  assign simm   = {{16{imm[15]}}, imm};
  assign a      = rf[rs1];
  assign b      = rf[rs2];
  assign d      = rf[rd];
  assign ea     = a + simm;
  assign pc_inc = pc + 32'd4;
  assign pc_br  = pc + {simm[29:0], 2'b00};

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] f,
                                            input logic signed [DATA_W-1:0] x,
                                            input logic signed [DATA_W-1:0] y);
    case (f)
      3'd0:    alu = x + y;
      3'd1:    alu = x - y;
      3'd2:    alu = x & y;
      3'd3:    alu = x | y;
      3'd4:    alu = x ^ y;
      3'd5:    alu = x << y[4:0];
      3'd6:    alu = x >> y[4:0];
      default: alu = {31'b0, x < y};
    endcase
  endfunction

  always_comb begin
    wb_en  = 1'b0;
    wb_val = alu(op[2:0], a, b);
    pc_nxt = pc_inc;
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03,
      6'h04, 6'h05, 6'h06, 6'h07: wb_en = 1'b1;
      OP_ADDI: begin wb_en = 1'b1; wb_val = ea; end
      OP_ORI:  begin wb_en = 1'b1; wb_val = a | {16'b0, imm}; end
      OP_LUI:  begin wb_en = 1'b1; wb_val = {imm, 16'b0}; end
      OP_BEQ:  if (d == a) pc_nxt = pc_br;
      OP_BNE:  if (d != a) pc_nxt = pc_br;
      OP_JAL:  begin wb_en = 1'b1; wb_val = pc_inc; pc_nxt = pc_br; end
      OP_JALR: begin wb_en = 1'b1; wb_val = pc_inc; pc_nxt = ea & ~32'd3; end
`ifdef KTC32_HALT_EN
      OP_HALT: pc_nxt = pc;
`endif
      default: ;
    endcase
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:  state_nxt = S_EX;
      S_EX: begin
        state_nxt = S_IF;
        if (op == OP_LW) state_nxt = S_MEM;
`ifdef KTC32_HALT_EN
        if (op == OP_HALT) state_nxt = S_HALT;
`endif
      end
      S_MEM: state_nxt = S_IF;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    ram_addr  = pc[11:2];
    ram_we    = 1'b0;
    ram_wdata = d;
    if (state == S_EX && (op == OP_LW || op == OP_SW)) ram_addr = ea[11:2];
    if (state == S_EX && op == OP_SW && !ea[31] && !reset) ram_we = 1'b1;
  end

  ktc32_ram ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      led    <= '0;
      ld_rd  <= '0;
      ld_led <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_EX: begin
          if (wb_en && rd != 4'd0) rf[rd] <= wb_val;
          if (op == OP_SW && ea[31]) led <= d[3:0];
          ld_rd  <= rd;
          ld_led <= ea[31];
          if (op != OP_LW) pc <= pc_nxt;
        end
        S_MEM: begin
          if (ld_rd != 4'd0) rf[ld_rd] <= ld_led ? {28'b0, led} : ram_rdata;
          pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ktc32_top.sv
// Directed-program bench for ktc32_top: programs are preloaded into dut.ram.mem and
// results are observed on led, in RAM, and on the fetch PC.
module tb_ktc32_top;
  logic       clk;
  logic       reset;
  logic [3:0] led;
  int         n_vec;
  int         n_err;

  ktc32_top dut (
    .clk   (clk),
    .reset (reset),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 14'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 2'b00, imm};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset, wipe RAM; caller then loads a program and calls release_reset.
  task automatic hold_reset();
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 1024; i++) dut.ram.mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_led_prog();
    dut.ram.mem[0] = enc_i(6'h0A, 4'd1, 4'd0, 16'h8000);
    dut.ram.mem[1] = enc_i(6'h08, 4'd2, 4'd0, 16'd5);
    dut.ram.mem[2] = enc_i(6'h11, 4'd2, 4'd1, 16'd0);
    dut.ram.mem[3] = enc_i(6'h1A, 4'd0, 4'd0, 16'd0);
  endtask

  logic [3:0]  st_regs [0:8];
  logic [31:0] st_exp  [0:8];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;

    // LED store: led changes on the edge ending the 6th cycle
    hold_reset();
    load_led_prog();
    release_reset();
    check("led_pre", {28'b0, led}, 32'h0);
    step(5);
    check("led_store_c5", {28'b0, led}, 32'h0);
    step(1);
    check("led_store_c6", {28'b0, led}, 32'h5);

    // ALU sequence
    st_regs = '{4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    st_exp  = '{32'h4, 32'hFFFFFFF6, 32'h1, 32'hFFFFFFFA, 32'h380,
                32'h01FFFFFF, 32'h5, 32'hFFFFFFFF, 32'h00008001};
    hold_reset();
    dut.ram.mem[0]  = enc_i(6'h08, 4'd1, 4'd0, 16'hFFFD);
    dut.ram.mem[1]  = enc_i(6'h08, 4'd2, 4'd0, 16'd7);
    dut.ram.mem[2]  = enc_r(6'h00, 4'd3, 4'd1, 4'd2);
    dut.ram.mem[3]  = enc_r(6'h01, 4'd4, 4'd1, 4'd2);
    dut.ram.mem[4]  = enc_r(6'h07, 4'd5, 4'd1, 4'd2);
    dut.ram.mem[5]  = enc_r(6'h04, 4'd7, 4'd1, 4'd2);
    dut.ram.mem[6]  = enc_r(6'h05, 4'd8, 4'd2, 4'd2);
    dut.ram.mem[7]  = enc_r(6'h06, 4'd9, 4'd1, 4'd2);
    dut.ram.mem[8]  = enc_r(6'h02, 4'd10, 4'd1, 4'd2);
    dut.ram.mem[9]  = enc_r(6'h03, 4'd11, 4'd1, 4'd2);
    dut.ram.mem[10] = enc_i(6'h09, 4'd12, 4'd0, 16'h8001);
    for (int k = 0; k < 9; k++)
      dut.ram.mem[11+k] = enc_i(6'h11, st_regs[k], 4'd0, 16'(16'h200 + 4*k));
    dut.ram.mem[20] = enc_i(6'h0A, 4'd6, 4'd0, 16'h8000);
    dut.ram.mem[21] = enc_i(6'h11, 4'd3, 4'd6, 16'd0);
    dut.ram.mem[22] = enc_i(6'h1A, 4'd0, 4'd0, 16'd0);
    release_reset();
    step(60);
    for (int k = 0; k < 9; k++)
      check($sformatf("alu_r%0d", st_regs[k]), dut.ram.mem[128+k], st_exp[k]);
    check("alu_led", {28'b0, led}, 32'h4);

    // Reset after a run: led, PC and state return to their reset values
    reset = 1'b1;
    step(1);
    check("rst_led", {28'b0, led}, 32'h0);
    check("rst_pc", dut.pc, 32'h0);
    check("rst_state", 32'(dut.state), 32'h0);
    reset = 1'b0;
    check("rst_fetch_addr", {22'b0, dut.ram_addr}, 32'h0);

    // Memory round trip; the load must take exactly 3 cycles
    hold_reset();
    dut.ram.mem[0]  = enc_i(6'h08, 4'd1, 4'd0, 16'h000A);
    dut.ram.mem[1]  = enc_i(6'h11, 4'd1, 4'd0, 16'h0100);
    dut.ram.mem[2]  = enc_i(6'h10, 4'd2, 4'd0, 16'h0100);
    dut.ram.mem[3]  = enc_i(6'h0A, 4'd3, 4'd0, 16'h8000);
    dut.ram.mem[4]  = enc_i(6'h11, 4'd2, 4'd3, 16'd0);
    dut.ram.mem[5]  = enc_i(6'h10, 4'd4, 4'd3, 16'd0);
    dut.ram.mem[6]  = enc_i(6'h11, 4'd4, 4'd0, 16'h0104);
    dut.ram.mem[7]  = enc_i(6'h10, 4'd5, 4'd0, 16'h1102);
    dut.ram.mem[8]  = enc_i(6'h08, 4'd5, 4'd5, 16'd1);
    dut.ram.mem[9]  = enc_i(6'h11, 4'd5, 4'd0, 16'h0108);
    dut.ram.mem[10] = enc_i(6'h1A, 4'd0, 4'd0, 16'd0);
    release_reset();
    step(10);
    check("ld_led_c10", {28'b0, led}, 32'h0);
    step(1);
    check("ld_led_c11", {28'b0, led}, 32'hA);
    step(40);
    check("ram_0x100", dut.ram.mem[64], 32'hA);
    check("led_readback", dut.ram.mem[65], 32'hA);
    check("wrap_unaligned_ld", dut.ram.mem[66], 32'hB);

    // Branch loop, JAL/JALR links, r0 hardwired
    hold_reset();
    dut.ram.mem[0]  = enc_i(6'h08, 4'd1, 4'd0, 16'd0);
    dut.ram.mem[1]  = enc_i(6'h08, 4'd2, 4'd0, 16'd9);
    dut.ram.mem[2]  = enc_i(6'h08, 4'd1, 4'd1, 16'd1);
    dut.ram.mem[3]  = enc_i(6'h19, 4'd1, 4'd2, 16'hFFFF);
    dut.ram.mem[4]  = enc_i(6'h0A, 4'd3, 4'd0, 16'h8000);
    dut.ram.mem[5]  = enc_i(6'h11, 4'd1, 4'd3, 16'd0);
    dut.ram.mem[6]  = enc_i(6'h1A, 4'd4, 4'd0, 16'd1);
    dut.ram.mem[7]  = enc_i(6'h08, 4'd0, 4'd0, 16'd1);
    dut.ram.mem[8]  = enc_i(6'h11, 4'd4, 4'd0, 16'h0200);
    dut.ram.mem[9]  = enc_i(6'h11, 4'd0, 4'd0, 16'h0204);
    dut.ram.mem[10] = enc_i(6'h18, 4'd0, 4'd0, 16'd2);
    dut.ram.mem[11] = enc_i(6'h11, 4'd1, 4'd0, 16'h0208);
    dut.ram.mem[12] = enc_i(6'h1B, 4'd6, 4'd0, 16'h003A);
    dut.ram.mem[13] = enc_i(6'h11, 4'd1, 4'd0, 16'h020C);
    dut.ram.mem[14] = enc_i(6'h11, 4'd6, 4'd0, 16'h0210);
    dut.ram.mem[15] = enc_i(6'h1A, 4'd0, 4'd0, 16'd0);
    dut.ram.mem[129] = 32'hDEAD;
    release_reset();
    step(120);
    check("loop_led", {28'b0, led}, 32'h9);
    check("jal_link", dut.ram.mem[128], 32'd28);
    check("r0_zero", dut.ram.mem[129], 32'h0);
    check("beq_skip", dut.ram.mem[130], 32'h0);
    check("jalr_skip", dut.ram.mem[131], 32'h0);
    check("jalr_link", dut.ram.mem[132], 32'd52);

    // Reset during the EX cycle of the LED store
    hold_reset();
    load_led_prog();
    release_reset();
    step(5);
    reset = 1'b1;
    step(1);
    check("midrst_led", {28'b0, led}, 32'h0);
    check("midrst_pc", dut.pc, 32'h0);
    reset = 1'b0;
    step(5);
    check("rerun_c5", {28'b0, led}, 32'h0);
    step(1);
    check("rerun_c6", {28'b0, led}, 32'h5);

    // Opcode 0x3F before an LED store
    hold_reset();
    dut.ram.mem[0] = enc_i(6'h0A, 4'd1, 4'd0, 16'h8000);
    dut.ram.mem[1] = enc_i(6'h08, 4'd2, 4'd0, 16'd3);
    dut.ram.mem[2] = 32'hFC000000;
    dut.ram.mem[3] = enc_i(6'h11, 4'd2, 4'd1, 16'd0);
    dut.ram.mem[4] = enc_i(6'h1A, 4'd0, 4'd0, 16'd0);
    release_reset();
    step(20);
`ifdef KTC32_HALT_EN
    check("halt_led", {28'b0, led}, 32'h0);
    check("halt_pc", dut.pc, 32'h8);
`else
    check("op3f_nop_led", {28'b0, led}, 32'h3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ktc32_top.md
# ktc32_top

Single-clock SoC top for the Arty S7 board: a compact 32-bit multi-cycle KTC32 core, a 4 KiB unified instruction/data RAM and a memory-mapped 4-bit LED register. Execution starts from address 0 after reset. The program image is preloaded into the RAM array by hierarchical path. The block is the FPGA top level.

## Interface
- Parameters: none; RAM depth fixed at 1024 x 32-bit words.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `led`  out  4  LED register output.
- Instance `ram` must exist, holding array `mem` declared `logic [31:0] mem [0:1023]`, loadable by `$readmemh`; word i sits at byte address 4*i.

## Operation
- 16 GPRs x 32 bit; r0 reads 0, writes to it are discarded. PC is byte-addressed, word-aligned; sequential PC+4.
- Instruction fields: op [31:26], rd [25:22], rs1 [21:18], rs2 [17:14], imm [15:0]. simm = sign-extended imm.
- R-type (rd = rs1 op rs2): 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLL, 0x06 SRL, 0x07 SLT (signed, result 1/0). Shifts use rs2[4:0]. Arithmetic is modulo 2^32.
- I-type:
  - 0x08 ADDI: rd = rs1 + simm.
  - 0x09 ORI: rd = rs1 | zero-extended imm.
  - 0x0A LUI: rd = imm << 16.
- Memory:
  - 0x10 LW: rd = M[rs1 + simm].
  - 0x11 SW: M[rs1 + simm] = r[rd].
  - Address bits [1:0] are ignored.
- Control:
  - 0x18 BEQ / 0x19 BNE: compare r[rd] with r[rs1]; if taken, PC = PC + (simm << 2), else PC + 4.
  - 0x1A JAL: rd = PC + 4; PC = PC + (simm << 2).
  - 0x1B JALR: rd = PC + 4; PC = (rs1 + simm) & ~3. Operands are read before rd is written.
- Every other opcode executes as a NOP, except 0x3F when the halt feature is enabled (see Configuration).
- Address map:
  - addr[31] = 0: RAM, word index addr[11:2]; higher address bits are ignored, so the RAM wraps.
  - addr[31] = 1: LED register. SW sets `led` to data[3:0]. LW returns {28'b0, led}.
- RAM: single port with synchronous read, and write on the clock edge. Reset does not alter its contents.

## Timing
- FSM states: IF, EX, MEM.
  - IF: RAM address = PC. The instruction is latched at the end of the cycle. Next state EX.
  - EX: ALU, branch and jump results are written and the PC is updated, then return to IF. For SW, the write happens on the EX edge, then IF. For LW, the address is issued, then MEM.
  - MEM: read data is written to rd, PC += 4, then IF.
- Latency: LW takes 3 cycles. Every other instruction takes 2 cycles.
- `led` changes on the clock edge that ends the EX cycle of a store to an LED address.
- Reset values: PC = 0, state IF, `led` = 0, all GPRs = 0.
- Reset has priority in every state. If reset is asserted in the EX cycle of a store, no RAM or LED write occurs. If reset is asserted in the MEM cycle of a load, rd is not written.
- First fetch of address 0 is in the cycle after reset deasserts.

## Configuration
- `KTC32_HALT_EN` defined: opcode 0x3F enters a HALTED state. PC, GPRs and `led` freeze; only reset leaves HALTED.
- Not defined: 0x3F is a NOP, and the FSM has only IF, EX and MEM.

## Test plan
- Reset check: assert reset for 1 cycle -> `led` = 0, PC = 0, first RAM read at address 0.
- LED store: program `LUI r1,0x8000; ADDI r2,r0,5; SW r2,0(r1)` -> `led` = 4'b0101 within 6 cycles of reset release.
- ALU sequence: `ADDI r1,r0,-3; ADDI r2,r0,7; ADD/SUB/SLT` -> r3 = 4, r4 = 0xFFFFFFF6, r5 = 1. Store r3[3:0] to the LED address -> `led` = 4'b0100.
- Memory round trip: SW 0xA to address 0x100, then LW it back and store it to the LED address -> `led` = 4'b1010. The load takes exactly 3 cycles.
- Branch loop: r1 counts 0..9 with BNE back-edge, then is written to the LED address -> `led` = 4'b1001. Also check that JAL writes the link value PC+4 and that r0 stays 0 after `ADDI r0,r0,1`.
- Mid-run reset: assert reset during the EX cycle of an LED store -> `led` stays 0 and the program re-executes from PC = 0.
- With `KTC32_HALT_EN`: 0x3F followed by a store to the LED address -> `led` is unchanged until reset.
